fp32_dot_seq: RTL and testbench

Dot-product initiator that drives an fp32 MAC (mul 2 + add 3 pipe, accumulator mode) from a ready/valid operand stream. It accepts a job of length LEN, clears the MAC accumulator and issues LEN (a,b) pairs with use_acc=1. Issues are spaced so each accumulate reads the committed previous sum. It then waits for the final MAC result and presents it on a ready/valid result port. It sits between the operand fetch logic and one fp32 MAC lane of the systolic array.

---
 rtl/fp32_dot_seq.sv | 142 ++++++++++++++
 tb/tb_fp32_dot_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_dot_seq.sv
// fp32 dot-product sequencer: streams operand pairs into one accumulating MAC lane.
// Optional FP32_DOT_SEQ_PERF_EN adds a job-latency counter on perf_cycles.
module fp32_dot_seq #(
  parameter int LEN_W     = 16,
  parameter int ISSUE_GAP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             mac_valid_in,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_use_acc,
  output logic             mac_clr_acc,
  input  logic             mac_valid_out,
  input  logic [31:0]      mac_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [LEN_W-1:0] res_count,
  output logic             err
`ifdef FP32_DOT_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LEN_W-1:0] GAP_LD = LEN_W'(ISSUE_GAP - 1);
  localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] outstanding;
  logic [LEN_W-1:0] gap;
  logic             issue;
  logic             ret;
  logic             last_ret;

  assign job_ready   = (state == S_IDLE);
  assign op_ready    = (state == S_ISSUE) && (gap == '0) && (issued < len_q);
  assign issue       = op_ready && op_valid;
  assign mac_valid_in = issue;
  assign mac_a       = issue ? op_a : '0;
  assign mac_b       = issue ? op_b : '0;
  assign mac_c       = '0;
  assign mac_use_acc = (state != S_IDLE);
  assign mac_clr_acc = (state == S_CLEAR);
  assign res_valid   = (state == S_DONE);
  assign ret         = mac_valid_out;
  assign last_ret    = ret && (outstanding == ONE);

  // A return with nothing in flight is flagged and never underflows the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err         <= 1'b0;
      gap         <= '0;
    end else begin
      if (ret && (outstanding == '0)) begin
        err <= 1'b1;
        if (issue) outstanding <= ONE;
      end else if (issue && !ret) begin
        outstanding <= outstanding + ONE;
      end else if (!issue && ret) begin
        outstanding <= outstanding - ONE;
      end
      if (issue) gap <= GAP_LD;
      else if (gap != '0) gap <= gap - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      res_data  <= '0;
      res_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (job_valid) begin
            len_q  <= job_len;
            issued <= '0;
            if (job_len == '0) begin
              res_data  <= '0;
              res_count <= '0;
              state     <= S_DONE;
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: state <= S_ISSUE;
        S_ISSUE: begin
          if (issue) begin
            issued <= issued + ONE;
            if (issued + ONE == len_q) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_ret) begin
            res_data  <= mac_y;
            res_count <= len_q;
            state     <= S_DONE;
          end
        end
        S_DONE: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FP32_DOT_SEQ_PERF_EN
  // Starts at 1 on accept so the value at res_valid equals accept-to-result cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if ((state == S_IDLE) && job_valid) begin
      perf_cycles <= 32'd1;
    end else if ((state != S_IDLE) && (state != S_DONE)
                 && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp32_dot_seq.sv
// Directed bench for fp32_dot_seq with a 5-cycle accumulating MAC model.
// Each scenario task applies stimulus and checks its own expectations.
module tb_fp32_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_len;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mac_valid_in;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic [31:0] mac_c;
  logic        mac_use_acc;
  logic        mac_clr_acc;
  logic        mac_valid_out;
  logic [31:0] mac_y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [15:0] res_count;
  logic        err;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fp32_dot_seq #(.LEN_W(16), .ISSUE_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_valid_in(mac_valid_in), .mac_a(mac_a), .mac_b(mac_b),
    .mac_c(mac_c), .mac_use_acc(mac_use_acc), .mac_clr_acc(mac_clr_acc),
    .mac_valid_out(mac_valid_out), .mac_y(mac_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count), .err(err)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // MAC lane model: product enters a 5-stage pipe, accumulates on exit.
  logic [4:0] pv = '0;
  real        prod [5];
  real        acc = 0.0;
  logic       force_vo = 1'b0;

  initial for (int i = 0; i < 5; i++) prod[i] = 0.0;

  always @(posedge clk) begin
    pv <= {pv[3:0], mac_valid_in};
    prod[0] <= f2r(mac_a) * f2r(mac_b);
    for (int i = 1; i < 5; i++) prod[i] <= prod[i-1];
    if (mac_clr_acc) acc <= 0.0;
    else if (pv[4]) acc <= acc + prod[4];
  end

  assign mac_valid_out = pv[4] | force_vo;
  assign mac_y = r2f(acc + prod[4]);

  logic [31:0] opa [8];
  logic [31:0] opb [8];
  int acc_cyc, clr_cyc, n_clr, n_issue, first_iss, last_iss;
  int min_gap, max_gap, vo_cyc, rv_cyc, ready_idle, pass_bad;

  // Drives one job and records timing; comparisons live in the callers.
  task automatic run_job(input int n);
    int idx;
    idx = 0;
    acc_cyc = -1; clr_cyc = -1; n_clr = 0; n_issue = 0;
    first_iss = -1; last_iss = -1; min_gap = 1000; max_gap = 0;
    vo_cyc = -1; rv_cyc = -1; ready_idle = 0; pass_bad = 0;
    @(negedge clk);
    job_valid = 1'b1;
    job_len = 16'(n);
    for (int c = 0; c < 300; c++) begin
      op_valid = (idx < n);
      op_a = (idx < n) ? opa[idx] : 32'h0;
      op_b = (idx < n) ? opb[idx] : 32'h0;
      #1;
      if (job_valid && job_ready) acc_cyc = c;
      if (mac_clr_acc) begin n_clr++; clr_cyc = c; end
      if (op_ready && !mac_valid_in) ready_idle++;
      if (mac_valid_in) begin
        if (last_iss >= 0) begin
          if (c - last_iss < min_gap) min_gap = c - last_iss;
          if (c - last_iss > max_gap) max_gap = c - last_iss;
        end
        if (first_iss < 0) first_iss = c;
        last_iss = c;
        if (mac_a !== opa[idx] || mac_b !== opb[idx]) pass_bad++;
        n_issue++;
        idx++;
      end
      if (mac_valid_out) vo_cyc = c;
      if (res_valid) begin rv_cyc = c; break; end
      @(negedge clk);
      if (acc_cyc >= 0) job_valid = 1'b0;
    end
    op_valid = 1'b0;
    job_valid = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    job_valid = 1'b0; job_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nvec++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0 || op_ready !== 1'b0
        || mac_valid_in !== 1'b0 || mac_use_acc !== 1'b0
        || mac_clr_acc !== 1'b0 || err !== 1'b0 || res_data !== 32'h0
        || res_count !== 16'h0 || mac_c !== 32'h0) begin
      nfail++;
      $display("FAIL reset_outputs: jr=%b rv=%b or=%b vi=%b ua=%b ca=%b err=%b d=%h n=%0d want jr=1 rest 0",
               job_ready, res_valid, op_ready, mac_valid_in, mac_use_acc,
               mac_clr_acc, err, res_data, res_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_len2();
    opa[0] = 32'h3F800000; opb[0] = 32'h40400000;
    opa[1] = 32'h40000000; opb[1] = 32'h40800000;
    run_job(2);
    nvec++;
    if (res_data !== 32'h41300000) begin
      nfail++; $display("FAIL len2_data: got %h want 41300000", res_data);
    end
    nvec++;
    if (res_count !== 16'd2) begin
      nfail++; $display("FAIL len2_count: got %0d want 2", res_count);
    end
    nvec++;
    if (n_clr != 1 || clr_cyc != acc_cyc + 1 || clr_cyc >= first_iss) begin
      nfail++;
      $display("FAIL len2_clr: pulses=%0d at %0d first_issue=%0d want 1 at %0d",
               n_clr, clr_cyc, first_iss, acc_cyc + 1);
    end
    nvec++;
    if (pass_bad != 0 || n_issue != 2) begin
      nfail++;
      $display("FAIL len2_issue: bad=%0d issues=%0d want 0 and 2", pass_bad, n_issue);
    end
    handshake();
  endtask

  task automatic test_len1();
    opa[0] = 32'h40000000; opb[0] = 32'h40000000;
    run_job(1);
    nvec++;
    if (res_data !== 32'h40800000) begin
      nfail++; $display("FAIL len1_data: got %h want 40800000", res_data);
    end
    nvec++;
    if (n_issue != 1 || first_iss != acc_cyc + 2) begin
      nfail++;
      $display("FAIL len1_issue: issues=%0d at %0d want 1 at %0d",
               n_issue, first_iss, acc_cyc + 2);
    end
    nvec++;
    if (rv_cyc < 0 || rv_cyc != vo_cyc + 1 || vo_cyc != first_iss + 5) begin
      nfail++;
      $display("FAIL len1_latency: vo=%0d rv=%0d want vo=%0d rv=%0d",
               vo_cyc, rv_cyc, first_iss + 5, first_iss + 6);
    end
    handshake();
  endtask

  task automatic test_len8_gap();
    for (int i = 0; i < 8; i++) begin
      opa[i] = 32'h3F800000; opb[i] = 32'h3F800000;
    end
    run_job(8);
    nvec++;
    if (n_issue != 8 || min_gap != 4 || max_gap != 4) begin
      nfail++;
      $display("FAIL len8_gap: issues=%0d gap min=%0d max=%0d want 8 4 4",
               n_issue, min_gap, max_gap);
    end
    nvec++;
    if (ready_idle != 0) begin
      nfail++; $display("FAIL len8_ready: idle ready cycles=%0d want 0", ready_idle);
    end
    nvec++;
    if (res_count !== 16'd8 || res_data !== 32'h41000000) begin
      nfail++;
      $display("FAIL len8_result: got %0d %h want 8 41000000", res_count, res_data);
    end
    handshake();
  endtask

  task automatic test_len0();
    run_job(0);
    nvec++;
    if (n_issue != 0 || n_clr != 0) begin
      nfail++;
      $display("FAIL len0_mac: issues=%0d clr=%0d want 0 0", n_issue, n_clr);
    end
    nvec++;
    if (rv_cyc != acc_cyc + 1 || res_data !== 32'h0 || res_count !== 16'd0) begin
      nfail++;
      $display("FAIL len0_result: rv=%0d d=%h n=%0d want rv=%0d d=0 n=0",
               rv_cyc, res_data, res_count, acc_cyc + 1);
    end
    nvec++;
    if (err !== 1'b0) begin
      nfail++; $display("FAIL err_quiet: got %b want 0", err);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    opa[0] = 32'h3FC00000; opb[0] = 32'h40000000;
    run_job(1);
    nvec++;
    if (res_data !== 32'h40400000) begin
      nfail++; $display("FAIL bp_data: got %h want 40400000", res_data);
    end
    job_valid = 1'b1;
    job_len = 16'd0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (res_valid !== 1'b1 || res_data !== 32'h40400000
          || res_count !== 16'd1 || job_ready !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nfail++; $display("FAIL bp_hold: bad cycles=%0d want 0", bad);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    nvec++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      nfail++;
      $display("FAIL bp_release: rv=%b jr=%b want 0 1", res_valid, job_ready);
    end
    @(negedge clk);
    job_valid = 1'b0;
    #1;
    nvec++;
    if (res_valid !== 1'b1 || res_count !== 16'd0 || res_data !== 32'h0) begin
      nfail++;
      $display("FAIL bp_second: rv=%b n=%0d d=%h want 1 0 0",
               res_valid, res_count, res_data);
    end
    handshake();
  endtask

  task automatic test_err_idle();
    @(negedge clk);
    force_vo = 1'b1;
    @(negedge clk);
    force_vo = 1'b0;
    #1;
    nvec++;
    if (err !== 1'b1) begin
      nfail++; $display("FAIL err_set: got %b want 1", err);
    end
    repeat (4) @(negedge clk);
    #1;
    nvec++;
    if (err !== 1'b1 || job_ready !== 1'b1) begin
      nfail++; $display("FAIL err_sticky: err=%b jr=%b want 1 1", err, job_ready);
    end
  endtask

  task automatic test_reset_mid_issue();
    int seen;
    seen = 0;
    @(negedge clk);
    job_valid = 1'b1;
    job_len = 16'd8;
    op_a = 32'h3F800000;
    op_b = 32'h3F800000;
    op_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mac_valid_in) seen++;
      if (seen == 2) break;
      @(negedge clk);
    end
    nvec++;
    if (seen != 2) begin
      nfail++; $display("FAIL mid_issue_setup: issues=%0d want 2", seen);
    end
    @(negedge clk);
    rst_n = 1'b0;
    op_valid = 1'b0;
    #1;
    nvec++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0 || op_ready !== 1'b0
        || mac_valid_in !== 1'b0 || mac_use_acc !== 1'b0
        || mac_clr_acc !== 1'b0 || err !== 1'b0 || mac_a !== 32'h0
        || res_data !== 32'h0 || res_count !== 16'h0) begin
      nfail++;
      $display("FAIL mid_reset: jr=%b rv=%b or=%b vi=%b ua=%b ca=%b err=%b a=%h want jr=1 rest 0",
               job_ready, res_valid, op_ready, mac_valid_in, mac_use_acc,
               mac_clr_acc, err, mac_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    nvec++;
    if (err !== 1'b1 || job_ready !== 1'b1) begin
      nfail++;
      $display("FAIL stale_return: err=%b jr=%b want 1 1", err, job_ready);
    end
  endtask

  initial begin
    test_reset();
    test_len2();
    test_len1();
    test_len8_gap();
    test_len0();
    test_backpressure();
    test_err_idle();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
